oam_register_port: RTL
======================

Name: oam_register_port

Overview:
- Responder end of the sprite-memory register interface. Decodes PPU registers $2003 (OAMADDR) and $2004 (OAMDATA) on the shared memory bus.
- Owns the 256x8 OAM array and the auto-incrementing OAM pointer.
- Serves both CPU accesses and the OAM DMA engine's save/zero/stream/restore sequence.
- Exposes a second read-only port for the PPU sprite-evaluation logic.

Parameters:
- REG_OAMADDR, 16'h2003, bus address of the pointer register.
- REG_OAMDATA, 16'h2004, bus address of the data register.
- MIRROR_DECODE, 1, 1 = decode on bus_addr[15:13]==3'b001 plus bus_addr[2:0] (8-byte mirror); 0 = exact 16-bit match.
- RENDER_INC, 4, pointer increment for a $2004 write while rendering.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- bus_addr  in  16  shared memory-bus address
- bus_data_in  in  8  write data from bus master (CPU or DMA)
- bus_write_en  in  1  write strobe, may be held multiple cycles
- bus_data_out  out  8  registered read data
- bus_hit  out  1  registered; bus_addr decoded to $2003 or $2004 last cycle
- render_active  in  1  PPU is rendering visible or pre-render lines
- oamaddr_clear  in  1  one-cycle pulse from PPU timing; zeroes pointer
- ren_addr  in  8  sprite-evaluation read address
- ren_data  out  8  registered OAM[ren_addr], attribute-masked
- oam_addr_dbg  out  8  current pointer, for debug and bench

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-low.
- On rst==0 at the edge:
  - oam_addr=0, bus_data_out=0, bus_hit=0, ren_data=0.
  - Write-edge tracker is cleared.
  - OAM contents are not reset; they are undefined until written.
  - Reset mid-sequence abandons nothing: no pending state exists beyond the tracker.
- Write commit:
  - A write commits on a cycle with bus_write_en=1 and decoded register R, unless the previous cycle also had bus_write_en=1 with the same R.
  - A held strobe therefore commits exactly once.
  - A strobe that stays high while the address changes $2004->$2003 commits both.
- $2003 commit: oam_addr <= bus_data_in.
- $2004 commit, render_active=0:
  - OAM[oam_addr] <= bus_data_in.
  - oam_addr <= oam_addr+1, wrapping 8'hFF->8'h00.
- $2004 commit, render_active=1:
  - No array write.
  - oam_addr <= oam_addr+RENDER_INC, mod 256.
- Attribute mask: any read of byte index with addr[1:0]==2'b10 returns data & 8'hE3. This applies to bus reads of $2004 and to ren_data. Storage keeps the full byte.
- Read port, bus_data_out registered (1-cycle latency):
  - Value at edge N+1 uses bus_addr and pre-update oam_addr/array at edge N.
  - $2003 returns oam_addr. The DMA engine relies on this to save the pointer.
  - $2004 returns masked OAM[oam_addr].
  - Any other address returns 8'h00.
  - Reads never alter oam_addr.
- ren_data: registered masked OAM[ren_addr], 1-cycle latency, valid every cycle.
  - Same-cycle write to the same index returns the old data.
- Simultaneous events, same edge:
  - $2003 commit + oamaddr_clear: the $2003 value wins.
  - $2004 commit + oamaddr_clear: data is written at the old pointer; pointer becomes 0.
  - render_active has no effect on $2003 commits.
- Full 256-byte stream from pointer P: writes P..P+255 mod 256 and ends with pointer == P. No full or overflow condition exists.
- Write-edge tracker, two states:
  - IDLE -> HELD(R) on any commit.
  - HELD(R) -> HELD(R') on a commit to a different register.
  - HELD -> IDLE when bus_write_en=0 or the address is not decoded.

Decomposition:
- Shared package ppu_regs_pkg holds:
  - register address constants (2003/2004/4014)
  - OAM_DEPTH=256
  - ATTR_MASK=8'hE3
- These constants are also used by the DMA engine.
- One sub-module: oam_ram_2r1w, the 256x8 array with one synchronous write port and two registered read ports (bus, render).
- Decode, tracker and pointer logic stay in the top level.

Test Plan:
- Write $2003=8'h10, then $2004 with 8'hA0,A1,A2,A3 as one-cycle strobes -> OAM[10..13]=A0..A3, oam_addr_dbg=8'h14. Next-cycle read of $2003 gives 8'h14; ren_addr=8'h12 gives 8'hA2&E3=8'hA2.
- DMA-style sequence:
  - Read $2003 (pointer 8'h37), write $2003=0.
  - 256 $2004 writes of value i, each separated by 2 idle cycles.
  - Write $2003=8'h37.
  - Expected: OAM[i]=i (masked on idx%4==2), pointer passes through 0 after 256 writes, final 8'h37.
- Hold bus_write_en=1 at $2004 for 3 cycles with data 8'h5A at pointer 8'h20 -> only OAM[20]=5A written, pointer 8'h21. Then switch the held strobe to $2003 data 8'h00 -> pointer 0.
- render_active=1, pointer 8'h08, $2004 write 8'h55 -> OAM[08] unchanged, pointer 8'h0C. Pointer 8'hFE -> 8'h02.
- Same edge: oamaddr_clear with $2003 write 8'h40 -> pointer 8'h40. Same edge: clear with $2004 write 8'h77 at pointer 8'h05 -> OAM[05]=77, pointer 0.
- Assert rst=0 mid-stream at pointer 8'h80 -> next cycle pointer 0, bus_data_out=0, bus_hit=0. A strobe still held through reset release commits once.

Source files
------------

// File: rtl/ppu_regs_pkg.sv
// ============================================================================
// Module  : ppu_regs_pkg
// Brief   : PPU/APU register map and OAM constants shared by the sprite-memory
//           register port and the OAM DMA engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ppu_regs_pkg;

    localparam logic [15:0] PPU_OAMADDR = 16'h2003;
    localparam logic [15:0] PPU_OAMDATA = 16'h2004;
    localparam logic [15:0] APU_OAMDMA  = 16'h4014;

    localparam int          OAM_DEPTH   = 256;
    localparam logic [7:0]  ATTR_MASK   = 8'hE3;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ADDR = 2'd1,
        SEL_DATA = 2'd2
    } reg_sel_e;

    typedef enum logic {
        TRK_IDLE = 1'b0,
        TRK_HELD = 1'b1
    } trk_state_e;

    // Byte 2 of every sprite entry is the attribute byte; bits 4:2 read as zero.
    function automatic logic [7:0] oam_read_mask(input logic [7:0] idx,
                                                 input logic [7:0] data);
        return (idx[1:0] == 2'b10) ? (data & ATTR_MASK) : data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oam_ram_2r1w.sv
// ============================================================================
// Module  : oam_ram_2r1w
// Brief   : 256x8 OAM array, one synchronous write port and two registered,
//           attribute-masked read ports (bus and render).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_ram_2r1w
    import ppu_regs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  logic [7:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [7:0] i_bus_raddr,
    output logic [7:0] o_bus_rdata,
    input  logic [7:0] i_ren_raddr,
    output logic [7:0] o_ren_rdata
);

    logic [7:0] r_mem [OAM_DEPTH];
    logic [7:0] r_bus_rdata;
    logic [7:0] r_ren_rdata;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads sample the array before this edge's write: old data on collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bus_rdata <= 8'h00;
            r_ren_rdata <= 8'h00;
        end else begin
            r_bus_rdata <= oam_read_mask(i_bus_raddr, r_mem[i_bus_raddr]);
            r_ren_rdata <= oam_read_mask(i_ren_raddr, r_mem[i_ren_raddr]);
        end
    end

    assign o_bus_rdata = r_bus_rdata;
    assign o_ren_rdata = r_ren_rdata;

endmodule

`default_nettype wire

// File: rtl/oam_register_port.sv
// ============================================================================
// Module  : oam_register_port
// Brief   : Responder for PPU $2003/$2004: decode, write-edge tracking, OAM
//           pointer, and the OAM array with a sprite-evaluation read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_register_port
    import ppu_regs_pkg::*;
#(
    parameter logic [15:0] REG_OAMADDR   = PPU_OAMADDR,
    parameter logic [15:0] REG_OAMDATA   = PPU_OAMDATA,
    parameter bit          MIRROR_DECODE = 1'b1,
    parameter int          RENDER_INC    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_data_in,
    input  logic        bus_write_en,
    output logic [7:0]  bus_data_out,
    output logic        bus_hit,
    input  logic        render_active,
    input  logic        oamaddr_clear,
    input  logic [7:0]  ren_addr,
    output logic [7:0]  ren_data,
    output logic [7:0]  oam_addr_dbg
);

    localparam logic [7:0] c_render_inc = 8'(RENDER_INC);

    reg_sel_e   w_sel;
    logic       w_commit;
    logic       w_ram_we;
    logic [7:0] w_ram_bus;
    logic [7:0] w_bus_do;

    logic [7:0] r_ptr;
    trk_state_e r_trk_state;
    reg_sel_e   r_trk_sel;
    reg_sel_e   r_rd_sel;
    logic [7:0] r_rd_ptr;
    logic       r_hit;

    always_comb begin
        w_sel = SEL_NONE;
        if (MIRROR_DECODE) begin
            if (bus_addr[15:13] == 3'b001) begin
                if (bus_addr[2:0] == REG_OAMADDR[2:0]) begin
                    w_sel = SEL_ADDR;
                end else if (bus_addr[2:0] == REG_OAMDATA[2:0]) begin
                    w_sel = SEL_DATA;
                end
            end
        end else begin
            if (bus_addr == REG_OAMADDR) begin
                w_sel = SEL_ADDR;
            end else if (bus_addr == REG_OAMDATA) begin
                w_sel = SEL_DATA;
            end
        end
    end

    // A strobe held on the same register commits only on its first cycle.
    assign w_commit = bus_write_en && (w_sel != SEL_NONE) &&
                      !((r_trk_state == TRK_HELD) && (r_trk_sel == w_sel));
    assign w_ram_we = w_commit && (w_sel == SEL_DATA) && !render_active;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr       <= 8'h00;
            r_trk_state <= TRK_IDLE;
            r_trk_sel   <= SEL_NONE;
            r_rd_sel    <= SEL_NONE;
            r_rd_ptr    <= 8'h00;
            r_hit       <= 1'b0;
        end else begin
            r_hit    <= (w_sel != SEL_NONE);
            r_rd_sel <= w_sel;
            r_rd_ptr <= r_ptr;

            case (r_trk_state)
                TRK_IDLE: begin
                    if (w_commit) begin
                        r_trk_state <= TRK_HELD;
                        r_trk_sel   <= w_sel;
                    end
                end
                TRK_HELD: begin
                    if (!bus_write_en || (w_sel == SEL_NONE)) begin
                        r_trk_state <= TRK_IDLE;
                        r_trk_sel   <= SEL_NONE;
                    end else begin
                        r_trk_sel   <= w_sel;
                    end
                end
                default: begin
                    r_trk_state <= TRK_IDLE;
                    r_trk_sel   <= SEL_NONE;
                end
            endcase

            // $2003 beats the clear pulse; the clear beats a $2004 increment.
            if (w_commit && (w_sel == SEL_ADDR)) begin
                r_ptr <= bus_data_in;
            end else if (oamaddr_clear) begin
                r_ptr <= 8'h00;
            end else if (w_commit && (w_sel == SEL_DATA)) begin
                r_ptr <= r_ptr + (render_active ? c_render_inc : 8'd1);
            end
        end
    end

    oam_ram_2r1w u_ram (
        .clk         (clk),
        .rst         (rst),
        .i_we        (w_ram_we),
        .i_waddr     (r_ptr),
        .i_wdata     (bus_data_in),
        .i_bus_raddr (r_ptr),
        .o_bus_rdata (w_ram_bus),
        .i_ren_raddr (ren_addr),
        .o_ren_rdata (ren_data)
    );

    always_comb begin
        case (r_rd_sel)
            SEL_ADDR: w_bus_do = r_rd_ptr;
            SEL_DATA: w_bus_do = w_ram_bus;
            default:  w_bus_do = 8'h00;
        endcase
    end

    assign bus_data_out = w_bus_do;
    assign bus_hit      = r_hit;
    assign oam_addr_dbg = r_ptr;

endmodule

`default_nettype wire
